// File: rtl/ad_pkg.sv
// ad_pkg
// Shared definitions for the serial ADC receive path.
//   state_t          : receiver FSM state encoding (3-bit binary)
//   FRAME_W_DEF      : default sclk bits per conversion frame
//   DATA_W_DEF       : default result width (last bits of the frame)
//   DIV / DIV_HALF   : sclk generator period and high/low split in clk_sys
//                      cycles, so neighbours can derive strobe spacing
//   BIT_CNT_W        : width of the received-bit counter
//   STB_CNT_W        : width of the setup/hold strobe counter
package ad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int FRAME_W_DEF = 16;
    localparam int DATA_W_DEF  = 12;

    localparam int DIV      = 50;
    localparam int DIV_HALF = 25;

    localparam int BIT_CNT_W = 6;
    localparam int STB_CNT_W = 4;

endpackage

// File: rtl/ad_rx_shift.sv
// ad_rx_shift
// MSB-first shift register and received-bit counter for one ADC frame.
// Ports:
//   clk_sys  in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   load     in   clears register and bit counter ahead of a new frame
//   en       in   shift in one bit from sdo and advance the bit counter
//   sdo      in   serial data bit
//   data     out  the last DATA_W bits received (leading bits drop off)
//   last     out  the next enabled shift captures bit FRAME_W-1
module ad_rx_shift
    import ad_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
)
(
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic              sdo,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    logic [FRAME_W-1:0]   shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;

    // Shift register and bit counter. The concatenate-and-truncate form
    // keeps the shift legal even for a one-bit frame.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            shreg   <= FRAME_W'({shreg, sdo});
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign data = shreg[DATA_W-1:0];
    assign last = (bit_cnt == BIT_CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/ad_rx.sv
// ad_rx
// Serial ADC frame receiver. Drives chip select and a gated sclk, shifts
// in one frame MSB-first on the generator strobes and presents the result
// as a parallel sample with a one-cycle valid.
// Ports:
//   clk_sys     in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   sclk_in     in   free-running sclk level from the generator
//   sclk_pulse  in   strobe, the cycle before sclk_in rises
//   conv_req    in   conversion request pulse
//   adc_sdo     in   ADC serial data (already synchronised)
//   adc_cs_n    out  ADC chip select, active low, registered
//   adc_sclk    out  gated sclk, registered; idles high outside SHIFT
//   dout        out  last captured sample
//   dout_vld    out  one-cycle strobe, dout is new
//   busy        out  FSM is not IDLE
//   overrun     out  sticky, a request was lost
//   ovr_clr     in   clears overrun
module ad_rx
    import ad_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SETUP_P = 1,
    parameter int HOLD_P  = 1
)
(
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              sclk_pulse,
    input  logic              conv_req,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr
);

    state_t               state, state_nxt;
    logic [STB_CNT_W-1:0] stb_cnt, stb_cnt_nxt;
    logic                 pending, pending_nxt;
    logic                 overrun_nxt;
    logic                 cs_n_nxt;
    logic                 vld_nxt;
    logic [DATA_W-1:0]    dout_nxt;
    logic                 shift_load, shift_en, shift_last;
    logic [DATA_W-1:0]    shift_data;

    ad_rx_shift #(
        .FRAME_W (FRAME_W),
        .DATA_W  (DATA_W)
    ) u_shift (
        .clk_sys (clk_sys),
        .rst     (rst),
        .load    (shift_load),
        .en      (shift_en),
        .sdo     (adc_sdo),
        .data    (shift_data),
        .last    (shift_last)
    );

    // Next-state logic. Requests arriving while not idle queue into a
    // single pending slot; a second one is lost and flagged, and a new
    // loss beats a simultaneous ovr_clr. dout/dout_vld are loaded on the
    // HOLD->DONE transition so the valid strobe coincides with DONE.
    always_comb begin
        state_nxt   = state;
        stb_cnt_nxt = stb_cnt;
        pending_nxt = pending;
        overrun_nxt = overrun & ~ovr_clr;
        cs_n_nxt    = adc_cs_n;
        vld_nxt     = 1'b0;
        dout_nxt    = dout;
        shift_load  = 1'b0;
        shift_en    = 1'b0;

        if (conv_req && (state != ST_IDLE)) begin
            if (pending) begin
                overrun_nxt = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (conv_req || pending) begin
                    state_nxt   = ST_SETUP;
                    cs_n_nxt    = 1'b0;
                    stb_cnt_nxt = STB_CNT_W'(SETUP_P);
                    shift_load  = 1'b1;
                    // Servicing pending while a fresh request arrives
                    // leaves the fresh one queued.
                    pending_nxt = pending & conv_req;
                end
            end
            ST_SETUP: begin
                if (stb_cnt == '0) begin
                    state_nxt = ST_SHIFT;
                end else if (sclk_pulse) begin
                    stb_cnt_nxt = stb_cnt - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sclk_pulse) begin
                    shift_en = 1'b1;
                    if (shift_last) begin
                        state_nxt   = ST_HOLD;
                        stb_cnt_nxt = STB_CNT_W'(HOLD_P);
                    end
                end
            end
            ST_HOLD: begin
                if (stb_cnt == '0) begin
                    state_nxt = ST_DONE;
                    cs_n_nxt  = 1'b1;
                    vld_nxt   = 1'b1;
                    dout_nxt  = shift_data;
                end else if (sclk_pulse) begin
                    stb_cnt_nxt = stb_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers. adc_sclk follows sclk_in only while
    // shifting so the ADC sees no edges outside the data window.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= ST_IDLE;
            stb_cnt  <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            dout     <= '0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            stb_cnt  <= stb_cnt_nxt;
            pending  <= pending_nxt;
            overrun  <= overrun_nxt;
            adc_cs_n <= cs_n_nxt;
            adc_sclk <= (state == ST_SHIFT) ? sclk_in : 1'b1;
            dout     <= dout_nxt;
            dout_vld <= vld_nxt;
            busy     <= (state_nxt != ST_IDLE);
        end
    end

endmodule
